// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage. Commits register-file writes, hosts CP0, and takes exceptions and ERET.
// Optional macro WS_CP0_TIMER_EN enables Count/Compare and the timer interrupt (TI).
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 91
`endif
`ifndef WS_FWD_BUS_WD
`define WS_FWD_BUS_WD 41
`endif

module wb_stage #(
  parameter logic [31:0] EX_ENTRY     = 32'hbfc00380,
  parameter int          CNT_DIV_LOG2 = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  output logic                         ws_allowin,
  input  logic                         ms_to_ws_valid,
  input  logic [`MS_TO_WS_BUS_WD-1:0]  ms_to_ws_bus,
  input  logic [5:0]                   ext_int,
  output logic [3:0]                   rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [`WS_FWD_BUS_WD-1:0]    ws_fwd_bus,
  output logic                         flush,
  output logic [31:0]                  flush_pc,
  output logic                         has_int,
  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [4:0]                   debug_wb_rf_wnum,
  output logic [31:0]                  debug_wb_rf_wdata
);

  localparam logic [7:0] A_BADV    = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT   = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS  = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE   = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC     = {5'd14, 3'd0};

  logic                        ws_valid_q;
  logic [`MS_TO_WS_BUS_WD-1:0] bus_q;
  logic                        ready_go;

  logic        eret, mtc0, mfc0, ex, bd;
  logic [4:0]  cp0_rd, excode, dest;
  logic [2:0]  cp0_sel;
  logic [3:0]  bus_we;
  logic [31:0] result, pc;

  assign ready_go   = 1'b1;
  assign ws_allowin = !ws_valid_q || ready_go;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         ws_valid_q <= 1'b0;
    else if (ws_allowin) ws_valid_q <= ms_to_ws_valid;
  end

  // Payload is qualified by ws_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) bus_q <= ms_to_ws_bus;
  end

  assign {eret, mtc0, mfc0, cp0_rd, cp0_sel, bd, ex, excode, bus_we, dest, result, pc} = bus_q;

  logic [7:0]  cp0_addr;
  logic        cp0_wen;
  logic [31:0] epc_q, badv_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q, bd_q;
  logic [4:0]  exc_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic [31:0] count_rd, compare_rd, status_rd, cause_rd, cp0_rdata, final_result;
  logic        ti;

  assign cp0_addr = {cp0_rd, cp0_sel};
  assign cp0_wen  = ws_valid_q && mtc0 && !ex;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q   <= '0;
      badv_q  <= '0;
      im_q    <= '0;
      exl_q   <= 1'b0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      exc_q   <= '0;
      ip_hw_q <= '0;
      ip_sw_q <= '0;
    end else begin
      ip_hw_q <= ext_int;
      if (ws_valid_q && ex) begin
        exl_q <= 1'b1;
        exc_q <= excode;
        // A nested exception keeps the original return context.
        if (!exl_q) begin
          bd_q  <= bd;
          epc_q <= bd ? pc - 32'd4 : pc;
        end
        if (excode == 5'd4 || excode == 5'd5) badv_q <= result;
      end else if (ws_valid_q && eret) begin
        exl_q <= 1'b0;
      end else if (cp0_wen) begin
        case (cp0_addr)
          A_STATUS: begin
            im_q  <= result[15:8];
            exl_q <= result[1];
            ie_q  <= result[0];
          end
          A_CAUSE: ip_sw_q <= result[9:8];
          A_EPC:   epc_q   <= result;
          default: ;
        endcase
      end
    end
  end

`ifdef WS_CP0_TIMER_EN
  localparam int            DW      = CNT_DIV_LOG2 + 1;
  localparam logic [DW-1:0] DIV_MAX = DW'((1 << CNT_DIV_LOG2) - 1);

  logic [DW-1:0] div_q;
  logic [31:0]   count_q, compare_q;
  logic          ti_q, tick, wr_count, wr_compare;

  assign tick       = (div_q == DIV_MAX);
  assign wr_count   = cp0_wen && (cp0_addr == A_COUNT);
  assign wr_compare = cp0_wen && (cp0_addr == A_COMPARE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (wr_count)  count_q <= result;
      else if (tick) count_q <= count_q + 32'd1;
      if (wr_compare) compare_q <= result;
      // A Compare write wins over a match seen in the same cycle.
      if (wr_compare)                  ti_q <= 1'b0;
      else if (count_q == compare_q)   ti_q <= 1'b1;
    end
  end

  assign count_rd   = count_q;
  assign compare_rd = compare_q;
  assign ti         = ti_q;
`else
  logic unused_div_cfg;
  assign unused_div_cfg = (CNT_DIV_LOG2 >= 0);
  assign count_rd       = '0;
  assign compare_rd     = '0;
  assign ti             = 1'b0;
`endif

  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti, 14'b0, ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q, 1'b0, exc_q, 2'b0};

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      A_BADV:    cp0_rdata = badv_q;
      A_COUNT:   cp0_rdata = count_rd;
      A_COMPARE: cp0_rdata = compare_rd;
      A_STATUS:  cp0_rdata = status_rd;
      A_CAUSE:   cp0_rdata = cause_rd;
      A_EPC:     cp0_rdata = epc_q;
      default:   cp0_rdata = '0;
    endcase
  end

  assign final_result = mfc0 ? cp0_rdata : result;
  assign rf_we        = {4{ws_valid_q && !ex}} & bus_we;
  assign rf_waddr     = dest;
  assign rf_wdata     = final_result;
  assign ws_fwd_bus   = {rf_we, dest, final_result};

  assign flush    = ws_valid_q && (ex || eret);
  assign flush_pc = ex ? EX_ENTRY : epc_q;
  assign has_int  = ie_q && !exl_q && |(cause_rd[15:8] & im_q);

  assign debug_wb_pc       = pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: commit, exceptions, ERET, CP0 access and interrupts.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ms_to_ws_valid = 1'b0;
  logic [90:0] ms_to_ws_bus = '0;
  logic [5:0]  ext_int = '0;
  logic        ws_allowin, flush, has_int;
  logic [3:0]  rf_we, debug_wb_rf_wen;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [40:0] ws_fwd_bus;

  int n_checks = 0;
  int n_errors = 0;

  wb_stage dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ext_int(ext_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_bus(ws_fwd_bus),
    .flush(flush), .flush_pc(flush_pc), .has_int(has_int),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [90:0] mk(input logic eret, input logic mtc0, input logic mfc0,
                                     input logic [4:0] rd, input logic bd, input logic ex,
                                     input logic [4:0] excode, input logic [3:0] we,
                                     input logic [4:0] dest, input logic [31:0] result,
                                     input logic [31:0] pc);
    return {eret, mtc0, mfc0, rd, 3'd0, bd, ex, excode, we, dest, result, pc};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one instruction; on return it sits in WB and outputs can be sampled.
  task automatic issue(input logic [90:0] b);
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = b;
    step();
    ms_to_ws_valid = 1'b0;
  endtask

  task automatic wr_cp0(input logic [4:0] rd, input logic [31:0] val);
    issue(mk(0, 1, 0, rd, 0, 0, 5'd0, 4'h0, 5'd0, val, 32'hbfc0_0040));
    step();
  endtask

  task automatic rd_cp0(input string tag, input logic [4:0] rd, input logic [31:0] mask,
                        input logic [31:0] exp);
    issue(mk(0, 0, 1, rd, 0, 0, 5'd0, 4'hf, 5'd2, 32'h0, 32'hbfc0_0044));
    check(tag, 64'(rf_wdata & mask), 64'(exp));
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_rf_we", 64'(rf_we), 64'h0);
    check("rst_flush", 64'(flush), 64'h0);
    check("rst_has_int", 64'(has_int), 64'h0);
    check("rst_allowin", 64'(ws_allowin), 64'h1);
    rd_cp0("rst_status", 5'd12, 32'hffff_ffff, 32'h0040_0000);

    // Plain load commit.
    issue(mk(0, 0, 0, 5'd0, 0, 0, 5'd0, 4'b0011, 5'd5, 32'h1234_5678, 32'hbfc0_0010));
    check("ld_we", 64'(rf_we), 64'h3);
    check("ld_waddr", 64'(rf_waddr), 64'd5);
    check("ld_wdata", 64'(rf_wdata), 64'h1234_5678);
    check("ld_dbg_pc", 64'(debug_wb_pc), 64'hbfc0_0010);
    check("ld_dbg", 64'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
          64'({4'h3, 5'd5, 32'h1234_5678}));
    check("ld_fwd", 64'(ws_fwd_bus), 64'({4'h3, 5'd5, 32'h1234_5678}));
    check("ld_flush", 64'(flush), 64'h0);
    step();
    check("ld_drop", 64'(rf_we), 64'h0);

    // AdEL in a delay slot.
    issue(mk(0, 0, 0, 5'd0, 1, 1, 5'd4, 4'hf, 5'd7, 32'h0000_0003, 32'hbfc0_0100));
    check("adel_flush", 64'(flush), 64'h1);
    check("adel_fpc", 64'(flush_pc), 64'hbfc0_0380);
    check("adel_we", 64'(rf_we), 64'h0);
    step();
    check("adel_flush_off", 64'(flush), 64'h0);
    rd_cp0("adel_epc", 5'd14, 32'hffff_ffff, 32'hbfc0_00fc);
    rd_cp0("adel_badv", 5'd8, 32'hffff_ffff, 32'h0000_0003);
    rd_cp0("adel_cause", 5'd13, 32'h8000_007c, 32'h8000_0010);
    rd_cp0("adel_status", 5'd12, 32'hffff_ffff, 32'h0040_0002);

    // Nested exception carrying an mtc0 EPC: EPC, BD and BadVAddr hold.
    issue(mk(0, 1, 0, 5'd14, 0, 1, 5'd8, 4'h0, 5'd0, 32'hdead_beef, 32'hbfc0_0500));
    check("nest_fpc", 64'(flush_pc), 64'hbfc0_0380);
    step();
    rd_cp0("nest_epc", 5'd14, 32'hffff_ffff, 32'hbfc0_00fc);
    rd_cp0("nest_cause", 5'd13, 32'h8000_007c, 32'h8000_0020);
    rd_cp0("nest_badv", 5'd8, 32'hffff_ffff, 32'h0000_0003);

    // ERET back to a software-written EPC.
    wr_cp0(5'd14, 32'hbfc0_0200);
    issue(mk(1, 0, 0, 5'd0, 0, 0, 5'd0, 4'h0, 5'd0, 32'h0, 32'hbfc0_0600));
    check("eret_flush", 64'(flush), 64'h1);
    check("eret_fpc", 64'(flush_pc), 64'hbfc0_0200);
    step();
    rd_cp0("eret_status", 5'd12, 32'hffff_ffff, 32'h0040_0000);

    // ex and eret together: exception vector wins.
    issue(mk(1, 0, 0, 5'd0, 0, 1, 5'd8, 4'h0, 5'd0, 32'h0, 32'hbfc0_0300));
    check("prio_fpc", 64'(flush_pc), 64'hbfc0_0380);
    step();
    rd_cp0("prio_epc", 5'd14, 32'hffff_ffff, 32'hbfc0_0300);

    // Read-only and unmapped registers.
    wr_cp0(5'd8, 32'h0000_0055);
    rd_cp0("badv_ro", 5'd8, 32'hffff_ffff, 32'h0000_0003);
    wr_cp0(5'd3, 32'h1111_1111);
    rd_cp0("unmapped", 5'd3, 32'hffff_ffff, 32'h0);

    // External interrupt with IM2 and IE.
    wr_cp0(5'd12, 32'h0000_0401);
    rd_cp0("st_write", 5'd12, 32'hffff_ffff, 32'h0040_0401);
    ext_int = 6'b000001;
    check("int_not_yet", 64'(has_int), 64'h0);
    step();
    check("int_on", 64'(has_int), 64'h1);
    rd_cp0("cause_ip", 5'd13, 32'h0000_7f00, 32'h0000_0400);
    issue(mk(0, 0, 0, 5'd0, 0, 1, 5'd0, 4'h0, 5'd0, 32'h0, 32'hbfc0_0700));
    step();
    check("int_exl_mask", 64'(has_int), 64'h0);
    rd_cp0("int_epc", 5'd14, 32'hffff_ffff, 32'hbfc0_0700);
    ext_int = 6'b0;
    step();

`ifdef WS_CP0_TIMER_EN
    wr_cp0(5'd9, 32'd0);
    wr_cp0(5'd11, 32'd10);
    wr_cp0(5'd12, 32'h0040_8001);
    check("tmr_idle", 64'(has_int), 64'h0);
    for (int i = 0; i < 60 && !has_int; i++) step();
    check("tmr_int", 64'(has_int), 64'h1);
    rd_cp0("tmr_ti", 5'd13, 32'h4000_0000, 32'h4000_0000);
    issue(mk(0, 1, 0, 5'd11, 0, 0, 5'd0, 4'h0, 5'd0, 32'd1000, 32'hbfc0_0800));
    check("tmr_hold", 64'(has_int), 64'h1);
    step();
    check("tmr_clear", 64'(has_int), 64'h0);
`else
    wr_cp0(5'd9, 32'd5);
    rd_cp0("cnt_off", 5'd9, 32'hffff_ffff, 32'h0);
    wr_cp0(5'd11, 32'd7);
    rd_cp0("cmp_off", 5'd11, 32'hffff_ffff, 32'h0);
    rd_cp0("ti_off", 5'd13, 32'h4000_8000, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
